// File: rtl/pic_pkg.sv
// Shared constants for the PIC soft-core file-register bus and its peripherals.
// Base addresses are reused by the top-level read mux.
package pic_pkg;

    localparam int FILE_ADDR_W = 9;
    localparam int FILE_DATA_W = 8;

    localparam logic [FILE_ADDR_W-1:0] PORTA_ADDR = 9'h005;
    localparam logic [FILE_ADDR_W-1:0] TRISA_ADDR = 9'h085;
    localparam logic [FILE_ADDR_W-1:0] IOC_ADDR   = 9'h095;
    localparam logic [FILE_ADDR_W-1:0] IOCF_ADDR  = 9'h115;

    // True when [a, a+n) and [b, b+n) share an address.
    function automatic bit ranges_overlap(input int a, input int b, input int n);
        return (a < b + n) && (b < a + n);
    endfunction

endpackage

// File: rtl/pic_sync_bits.sv
// Multi-stage synchroniser for asynchronous pad inputs, one flop chain per bit.
// Latency STAGES cycles; no backpressure.
module pic_sync_bits #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             Clk,
    input  logic             nReset,
    input  logic [WIDTH-1:0] async_i,
    output logic [WIDTH-1:0] sync_o
);

    logic [STAGES-1:0][WIDTH-1:0] stage_q;

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            stage_q <= '0;
        end else begin
            stage_q[0] <= async_i;
            for (int s = 1; s < STAGES; s++) begin
                stage_q[s] <= stage_q[s-1];
            end
        end
    end

    assign sync_o = stage_q[STAGES-1];

endmodule

// File: rtl/pic_gpio_ports.sv
// GPIO ports with PORT/TRIS latches, input synchronisers and sticky interrupt-on-change.
// Writes land at the File_Latch edge; reads are combinational; pin-to-flag is SYNC_STAGES+1 edges.
module pic_gpio_ports
    import pic_pkg::*;
#(
    parameter int                      NUM_PORTS   = 2,
    parameter int                      PORT_WIDTH  = 8,
    parameter int                      SYNC_STAGES = 2,
    parameter logic [FILE_ADDR_W-1:0]  PORT_BASE   = PORTA_ADDR,
    parameter logic [FILE_ADDR_W-1:0]  TRIS_BASE   = TRISA_ADDR,
    parameter logic [FILE_ADDR_W-1:0]  IOC_BASE    = IOC_ADDR,
    parameter logic [FILE_ADDR_W-1:0]  IOCF_BASE   = IOCF_ADDR
) (
    input  logic                             Clk,
    input  logic                             nReset,
    input  logic [FILE_ADDR_W-1:0]           File_Address,
    input  logic [FILE_DATA_W-1:0]           File_Data_In,
    input  logic                             File_Latch,
    output logic [FILE_DATA_W-1:0]           File_Data_Out,
    output logic                             File_Hit,
    input  logic [NUM_PORTS*PORT_WIDTH-1:0]  Pin_In,
    output logic [NUM_PORTS*PORT_WIDTH-1:0]  Pin_Out,
    output logic [NUM_PORTS*PORT_WIDTH-1:0]  Pin_OE,
    output logic                             IOC_Int
);

    if (NUM_PORTS < 1 || NUM_PORTS > 8 || PORT_WIDTH < 1 || PORT_WIDTH > 8 || SYNC_STAGES < 2)
    begin : g_param_err
        $error("pic_gpio_ports: parameter out of range");
    end

    if (ranges_overlap(int'(PORT_BASE), int'(TRIS_BASE), NUM_PORTS) ||
        ranges_overlap(int'(PORT_BASE), int'(IOC_BASE),  NUM_PORTS) ||
        ranges_overlap(int'(PORT_BASE), int'(IOCF_BASE), NUM_PORTS) ||
        ranges_overlap(int'(TRIS_BASE), int'(IOC_BASE),  NUM_PORTS) ||
        ranges_overlap(int'(TRIS_BASE), int'(IOCF_BASE), NUM_PORTS) ||
        ranges_overlap(int'(IOC_BASE),  int'(IOCF_BASE), NUM_PORTS))
    begin : g_addr_overlap
        $error("pic_gpio_ports: register address ranges overlap");
    end

    typedef logic [NUM_PORTS-1:0][PORT_WIDTH-1:0] ports_t;

    ports_t port_q, port_d, tris_q, tris_d, ioc_q, ioc_d, iocf_q, iocf_d;
    ports_t sync_in, prev_q, chg;
    logic [NUM_PORTS-1:0] sel_port, sel_tris, sel_ioc, sel_iocf;
    logic [PORT_WIDTH-1:0] wr_dat;

    pic_sync_bits #(
        .WIDTH  (NUM_PORTS*PORT_WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .Clk     (Clk),
        .nReset  (nReset),
        .async_i (Pin_In),
        .sync_o  (sync_in)
    );

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_dec
        assign sel_port[p] = (File_Address == PORT_BASE + FILE_ADDR_W'(p));
        assign sel_tris[p] = (File_Address == TRIS_BASE + FILE_ADDR_W'(p));
        assign sel_ioc[p]  = (File_Address == IOC_BASE  + FILE_ADDR_W'(p));
        assign sel_iocf[p] = (File_Address == IOCF_BASE + FILE_ADDR_W'(p));
    end

    assign wr_dat = File_Data_In[PORT_WIDTH-1:0];
    assign chg    = sync_in ^ prev_q;

    always_comb begin
        port_d        = port_q;
        tris_d        = tris_q;
        ioc_d         = ioc_q;
        iocf_d        = iocf_q;
        File_Data_Out = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (File_Latch && sel_port[i]) port_d[i] = wr_dat;
            if (File_Latch && sel_tris[i]) tris_d[i] = wr_dat;
            if (File_Latch && sel_ioc[i])  ioc_d[i]  = wr_dat;
            if (File_Latch && sel_iocf[i]) iocf_d[i] = iocf_q[i] & wr_dat;
            // A change seen in the same cycle as a clear-write keeps its flag.
            iocf_d[i] = iocf_d[i] | (chg[i] & ioc_q[i]);

            if (sel_port[i]) File_Data_Out = File_Data_Out | FILE_DATA_W'(sync_in[i]);
            if (sel_tris[i]) File_Data_Out = File_Data_Out | FILE_DATA_W'(tris_q[i]);
            if (sel_ioc[i])  File_Data_Out = File_Data_Out | FILE_DATA_W'(ioc_q[i]);
            if (sel_iocf[i]) File_Data_Out = File_Data_Out | FILE_DATA_W'(iocf_q[i]);
        end
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            port_q <= '0;
            tris_q <= '1;
            ioc_q  <= '0;
            iocf_q <= '0;
            prev_q <= '0;
        end else begin
            port_q <= port_d;
            tris_q <= tris_d;
            ioc_q  <= ioc_d;
            iocf_q <= iocf_d;
            prev_q <= sync_in;
        end
    end

    assign File_Hit = |{sel_port, sel_tris, sel_ioc, sel_iocf};
    assign Pin_Out  = port_q;
    assign Pin_OE   = ~tris_q;
    assign IOC_Int  = |iocf_q;

    // Upper write-data bits are ignored for narrow ports.
    logic unused_dat;
    assign unused_dat = ^File_Data_In;

endmodule

// File: tb/tb_pic_gpio_ports.sv
// Bench for pic_gpio_ports: directed scenarios plus randomized bus/pin traffic against a history model.
// A second instance covers a 3x6-bit configuration.
module tb_pic_gpio_ports;

    localparam int S = 2;
    localparam logic [8:0] PB = 9'h005, TB = 9'h085, IB = 9'h095, FB = 9'h115;

    logic        Clk = 1'b0;
    logic        nReset;
    logic [8:0]  addr;
    logic [7:0]  wdat;
    logic        latch;
    logic [15:0] pin;
    logic [7:0]  rdat;
    logic        hit;
    logic [15:0] pout, poe;
    logic        ioc_int;

    logic [8:0]  addr6;
    logic [7:0]  rdat6;
    logic        hit6;
    logic [17:0] pin6, pout6, poe6;
    logic        int6;

    always #5 Clk = ~Clk;

    pic_gpio_ports u_dut (
        .Clk(Clk), .nReset(nReset), .File_Address(addr), .File_Data_In(wdat),
        .File_Latch(latch), .File_Data_Out(rdat), .File_Hit(hit), .Pin_In(pin),
        .Pin_Out(pout), .Pin_OE(poe), .IOC_Int(ioc_int)
    );

    pic_gpio_ports #(.NUM_PORTS(3), .PORT_WIDTH(6)) u_dut6 (
        .Clk(Clk), .nReset(nReset), .File_Address(addr6), .File_Data_In(8'h00),
        .File_Latch(1'b0), .File_Data_Out(rdat6), .File_Hit(hit6), .Pin_In(pin6),
        .Pin_Out(pout6), .Pin_OE(poe6), .IOC_Int(int6)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Reference model: register contents plus the list of pin values seen at each edge.
    logic [7:0]  m_port[2], m_tris[2], m_ioc[2], m_iocf[2];
    logic [15:0] hist[$];

    task automatic m_reset();
        for (int p = 0; p < 2; p++) begin
            m_port[p] = 8'h00; m_tris[p] = 8'hFF; m_ioc[p] = 8'h00; m_iocf[p] = 8'h00;
        end
        hist.delete();
        repeat (S + 1) hist.push_back(16'h0000);
    endtask

    function automatic logic [15:0] m_sync();
        return hist[hist.size() - S];
    endfunction

    task automatic m_read(input logic [8:0] a, output logic h, output logic [7:0] d);
        logic [15:0] sv;
        sv = m_sync();
        h = 1'b0;
        d = 8'h00;
        for (int p = 0; p < 2; p++) begin
            if (a == PB + p) begin h = 1'b1; d = sv[p*8 +: 8]; end
            if (a == TB + p) begin h = 1'b1; d = m_tris[p]; end
            if (a == IB + p) begin h = 1'b1; d = m_ioc[p]; end
            if (a == FB + p) begin h = 1'b1; d = m_iocf[p]; end
        end
    endtask

    task automatic m_edge();
        int n;
        logic [15:0] chg;
        logic [7:0] nf;
        if (!nReset) return;
        n = hist.size() - 1;
        // Value synchronised at this edge vs. value one edge older.
        chg = hist[n - S + 1] ^ hist[n - S];
        for (int p = 0; p < 2; p++) begin
            nf = m_iocf[p];
            if (latch && addr == FB + p) nf = nf & wdat;
            nf = nf | (chg[p*8 +: 8] & m_ioc[p]);
            if (latch && addr == PB + p) m_port[p] = wdat;
            if (latch && addr == TB + p) m_tris[p] = wdat;
            if (latch && addr == IB + p) m_ioc[p]  = wdat;
            m_iocf[p] = nf;
        end
        hist.push_back(pin);
        if (hist.size() > 8) void'(hist.pop_front());
    endtask

    task automatic check_model();
        logic h;
        logic [7:0] d;
        logic [15:0] exp_oe;
        m_read(addr, h, d);
        exp_oe = ~{m_tris[1], m_tris[0]};
        chk("file_hit", hit, h);
        chk("file_data", rdat, d);
        chk("pin_out", pout, {m_port[1], m_port[0]});
        chk("pin_oe", poe, exp_oe);
        chk("ioc_int", ioc_int, |{m_iocf[1], m_iocf[0]});
    endtask

    task automatic set_in(input logic [8:0] a, input logic [7:0] d, input logic l, input logic [15:0] pn);
        addr = a; wdat = d; latch = l; pin = pn;
        #1;
        check_model();
    endtask

    task automatic step();
        @(posedge Clk);
        m_edge();
        @(negedge Clk);
    endtask

    initial begin
        nReset = 1'b0;
        addr = TB; wdat = 8'h00; latch = 1'b0; pin = 16'h0000;
        addr6 = 9'h000; pin6 = 18'h0;
        m_reset();
        @(negedge Clk); @(negedge Clk);
        #1;
        chk("rst_tris0", rdat, 8'hFF);
        chk("rst_pin_out", pout, 16'h0000);
        chk("rst_pin_oe", poe, 16'h0000);
        chk("rst_ioc_int", ioc_int, 1'b0);
        nReset = 1'b1;
        @(negedge Clk);

        // Direction and output latch on port 1
        set_in(TB + 9'd1, 8'hF0, 1'b1, 16'h0000); step();
        set_in(PB + 9'd1, 8'hA5, 1'b1, 16'h0000);
        chk("oe_port1", poe[15:8], 8'h0F);
        step();
        set_in(TB + 9'd1, 8'h00, 1'b0, 16'h0000);
        chk("out_port1", pout[15:8], 8'hA5);
        chk("tris1_read", rdat, 8'hF0);
        step();

        // Synchroniser latency
        set_in(PB, 8'h00, 1'b0, 16'h000C);
        chk("sync_e0", rdat[3:0], 4'h0);
        step();
        set_in(PB, 8'h00, 1'b0, 16'h000C);
        chk("sync_e1", rdat[3:0], 4'h0);
        step();
        set_in(PB, 8'h00, 1'b0, 16'h000C);
        chk("sync_e2", rdat[3:0], 4'hC);
        step();

        // IOC on bit 0
        set_in(IB, 8'h01, 1'b1, 16'h000C); step();
        for (int e = 0; e < 3; e++) begin
            set_in(FB, 8'h00, 1'b0, 16'h000D);
            chk("iocf_early", rdat, 8'h00);
            step();
        end
        set_in(FB, 8'h00, 1'b0, 16'h000D);
        chk("iocf_e3", rdat, 8'h01);
        chk("ioc_int_e3", ioc_int, 1'b1);
        step();
        set_in(FB, 8'h00, 1'b1, 16'h000D); step();
        set_in(FB, 8'h00, 1'b0, 16'h000D);
        chk("iocf_cleared", rdat, 8'h00);
        step();

        // Masked bit 1 toggles: no flag
        for (int e = 0; e < 4; e++) begin
            set_in(FB, 8'h00, 1'b0, 16'h000F); step();
        end
        set_in(FB, 8'h00, 1'b0, 16'h000F);
        chk("masked_no_flag", rdat, 8'h00);
        chk("masked_no_int", ioc_int, 1'b0);
        step();

        // Clear-write coincident with a new detected change: set wins
        set_in(FB, 8'h00, 1'b0, 16'h000E); step();
        set_in(FB, 8'h00, 1'b0, 16'h000E); step();
        set_in(FB, 8'h00, 1'b1, 16'h000E); step();
        set_in(FB, 8'h00, 1'b0, 16'h000E);
        chk("set_beats_clear", rdat, 8'h01);
        step();
        set_in(FB, 8'h00, 1'b1, 16'h000E); step();
        set_in(FB, 8'h00, 1'b0, 16'h000E);
        chk("quiet_clear_int", ioc_int, 1'b0);
        step();

        // Randomized bus and pin traffic
        for (int c = 0; c < 400; c++) begin
            logic [8:0] a;
            logic [15:0] pn;
            case ($urandom_range(0, 4))
                0: a = PB; 1: a = TB; 2: a = IB; 3: a = FB;
                default: a = 9'($urandom);
            endcase
            a = a + 9'($urandom_range(0, 2));
            pn = ($urandom_range(0, 2) == 0) ? 16'($urandom) : pin;
            set_in(a, 8'($urandom), 1'($urandom), pn);
            if (c == 200) begin
                // Asynchronous reset in the middle of a write
                latch = 1'b1; addr = TB + 9'd1; wdat = 8'h00;
                #2;
                nReset = 1'b0;
                #1;
                m_reset();
                chk("arst_tris1", rdat, 8'hFF);
                chk("arst_pin_out", pout, 16'h0000);
                chk("arst_pin_oe", poe, 16'h0000);
                chk("arst_ioc_int", ioc_int, 1'b0);
                step();
                nReset = 1'b1;
                #1;
            end else begin
                step();
            end
        end

        // 3x6 configuration
        pin6 = {6'h2B, 12'h000};
        repeat (4) @(negedge Clk);
        addr6 = PB + 9'd2; #1;
        chk("p6_port2_read", rdat6, 8'h2B);
        chk("p6_port2_hit", hit6, 1'b1);
        addr6 = PB + 9'd3; #1;
        chk("p6_unmapped_hit", hit6, 1'b0);
        chk("p6_unmapped_data", rdat6, 8'h00);
        addr6 = TB + 9'd2; #1;
        chk("p6_tris2_read", rdat6, 8'h3F);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
